// File: rtl/spi_peripheral_if.sv
// CPU-side register interface of the SPI peripheral.
//   we/tx       : load the transmit holding register
//   tx_empty    : holding register free
//   rd          : acknowledge rx, clears rx_ready
//   rx/rx_ready : last completed received word and its unread flag
//   clr_err     : clear the sticky overrun/underrun flags
//   overrun     : a word completed while rx_ready was still set
//   underrun    : a word started while the holding register was empty
interface spi_peripheral_if #(
    parameter int unsigned WIDTH = 16
);
    logic             we;
    logic [WIDTH-1:0] tx;
    logic             tx_empty;
    logic             rd;
    logic [WIDTH-1:0] rx;
    logic             rx_ready;
    logic             clr_err;
    logic             overrun;
    logic             underrun;

    modport master (
        output we, tx, rd, clr_err,
        input  tx_empty, rx, rx_ready, overrun, underrun
    );

    modport slave (
        input  we, tx, rd, clr_err,
        output tx_empty, rx, rx_ready, overrun, underrun
    );
endinterface

// File: rtl/spi_peripheral.sv
// SPI responder (mode 3, MSB first) for the j1a I/O space.
// External pins are oversampled on clk; words of WIDTH bits are shifted
// while chip select is low, with back-to-back words needing no gap.
//   clk, reset    : system clock, synchronous active-high reset
//   cs_n_i        : external chip select, active low, asynchronous
//   sck_i, mosi_i : external SPI clock (idles high) and data in
//   miso_o        : serial data out, miso_oe_o its tristate enable
//   active_o      : synchronised chip select asserted
//   bus           : CPU-side holding/receive registers and flags
module spi_peripheral #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] TX_IDLE = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cs_n_i,
    input  logic            sck_i,
    input  logic            mosi_i,
    output logic            miso_o,
    output logic            miso_oe_o,
    output logic            active_o,
    spi_peripheral_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Synchronisers: sck has a third stage for edge detection; active_q is
    // the inverted second stage of cs_n.
    logic [2:0]       sck_q, sck_d;
    logic             cs_q, cs_d;
    logic             active_q, active_d;
    logic [1:0]       mosi_q, mosi_d;

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] tsr_q, tsr_d;
    logic [WIDTH-1:0] rsr_q, rsr_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             tx_empty_q, tx_empty_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic             rx_ready_q, rx_ready_d;
    logic             overrun_q, overrun_d;
    logic             underrun_q, underrun_d;
    logic             miso_q, miso_d;

    logic             sck_fall, sck_rise, word_done, overrun_set, underrun_set;

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q      <= '1;
            cs_q       <= 1'b1;
            active_q   <= 1'b0;
            mosi_q     <= '0;
            bit_cnt_q  <= '0;
            tsr_q      <= '0;
            rsr_q      <= '0;
            hold_q     <= '0;
            tx_empty_q <= 1'b1;
            rx_q       <= '0;
            rx_ready_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            active_q   <= active_d;
            mosi_q     <= mosi_d;
            bit_cnt_q  <= bit_cnt_d;
            tsr_q      <= tsr_d;
            rsr_q      <= rsr_d;
            hold_q     <= hold_d;
            tx_empty_q <= tx_empty_d;
            rx_q       <= rx_d;
            rx_ready_q <= rx_ready_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            miso_q     <= miso_d;
        end
    end

    // Next-state logic: shift engine, then CPU strobes, then flag priority
    always_comb begin
        sck_d        = {sck_q[1:0], sck_i};
        cs_d         = cs_n_i;
        active_d     = ~cs_q;
        mosi_d       = {mosi_q[0], mosi_i};
        bit_cnt_d    = bit_cnt_q;
        tsr_d        = tsr_q;
        rsr_d        = rsr_q;
        hold_d       = hold_q;
        tx_empty_d   = tx_empty_q;
        rx_d         = rx_q;
        rx_ready_d   = rx_ready_q;
        overrun_d    = overrun_q;
        underrun_d   = underrun_q;
        miso_d       = miso_q;
        word_done    = 1'b0;
        overrun_set  = 1'b0;
        underrun_set = 1'b0;

        sck_fall = active_q &  sck_q[2] & ~sck_q[1];
        sck_rise = active_q & ~sck_q[2] &  sck_q[1];

        if (!active_q) begin
            bit_cnt_d = '0;
            rsr_d     = '0;
        end else begin
            // Transmit side: load at word start, otherwise shift out
            if (sck_fall) begin
                if (bit_cnt_q == '0) begin
                    if (!tx_empty_q) begin
                        tsr_d      = hold_q;
                        tx_empty_d = 1'b1;
                    end else begin
                        tsr_d        = TX_IDLE;
                        underrun_set = 1'b1;
                    end
                end else begin
                    tsr_d = {tsr_q[WIDTH-2:0], 1'b0};
                end
                miso_d = tsr_d[WIDTH-1];
            end
            // Receive side: sample and count, wrapping at word end
            if (sck_rise) begin
                rsr_d = {rsr_q[WIDTH-2:0], mosi_q[1]};
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    word_done = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end

        // A write landing with a word-start consumption wins the holding register
        if (bus.we) begin
            hold_d     = bus.tx;
            tx_empty_d = 1'b0;
        end

        if (bus.rd) begin
            rx_ready_d = 1'b0;
        end
        if (word_done) begin
            rx_d       = rsr_d;
            rx_ready_d = 1'b1;
            if (rx_ready_q && !bus.rd) begin
                overrun_set = 1'b1;
            end
        end

        // Clearing yields to a same-cycle set event
        if (bus.clr_err) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
        if (underrun_set) begin
            underrun_d = 1'b1;
        end
    end

    assign miso_o       = miso_q;
    assign miso_oe_o    = active_q;
    assign active_o     = active_q;
    assign bus.tx_empty = tx_empty_q;
    assign bus.rx       = rx_q;
    assign bus.rx_ready = rx_ready_q;
    assign bus.overrun  = overrun_q;
    assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: a 16-bit and an 8-bit instance share the SPI pins.
// The stimulus thread drives mode-3 transfers and CPU strobes, updating a
// register-level model; completed words are queued and checked by a monitor.
module tb_spi_peripheral;
    localparam int unsigned H = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic cs_n  = 1'b1;
    logic sck   = 1'b1;
    logic mosi  = 1'b0;
    logic miso16, oe16, act16;
    logic miso8, oe8, act8;

    spi_peripheral_if #(.WIDTH(16)) bus16 ();
    spi_peripheral_if #(.WIDTH(8))  bus8 ();

    spi_peripheral #(.WIDTH(16), .TX_IDLE(16'h0000)) dut16 (
        .clk(clk), .reset(reset), .cs_n_i(cs_n), .sck_i(sck), .mosi_i(mosi),
        .miso_o(miso16), .miso_oe_o(oe16), .active_o(act16), .bus(bus16)
    );

    spi_peripheral #(.WIDTH(8), .TX_IDLE(8'h00)) dut8 (
        .clk(clk), .reset(reset), .cs_n_i(cs_n), .sck_i(sck), .mosi_i(mosi),
        .miso_o(miso8), .miso_oe_o(oe8), .active_o(act8), .bus(bus8)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Register-level model of the 16-bit instance
    logic [15:0] m_hold, m_rx;
    logic        m_empty, m_rdy, m_over, m_under;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_hold = '0; m_rx = '0; m_empty = 1'b1; m_rdy = 1'b0; m_over = 1'b0; m_under = 1'b0;
    endfunction

    function automatic void m_write(input logic [15:0] d);
        m_hold = d; m_empty = 1'b0;
    endfunction

    function automatic void m_clr();
        m_over = 1'b0; m_under = 1'b0;
    endfunction

    function automatic logic [15:0] m_start();
        if (m_empty) begin
            m_under = 1'b1;
            return 16'h0000;
        end
        m_empty = 1'b1;
        return m_hold;
    endfunction

    function automatic void m_complete(input logic [15:0] d, input logic rd);
        if (m_rdy && !rd) m_over = 1'b1;
        m_rdy = 1'b1;
        m_rx  = d;
        exp_q.push_back(d);
    endfunction

    // Monitor: a completion shows as rx_ready rising or rx changing while set
    logic        mon_prev_rdy = 1'b0;
    logic [15:0] mon_prev_rx  = '0;
    always @(negedge clk) begin
        logic [15:0] e;
        if (bus16.rx_ready === 1'b1 && (!mon_prev_rdy || bus16.rx !== mon_prev_rx)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got rx %0h expected no word", bus16.rx);
            end else begin
                e = exp_q.pop_front();
                if (bus16.rx !== e) begin
                    n_fail++;
                    $display("FAIL sb_rx: got %0h expected %0h", bus16.rx, e);
                end
            end
        end
        mon_prev_rdy = bus16.rx_ready;
        mon_prev_rx  = bus16.rx;
    end

    task automatic check_flags(input string tag);
        chk({tag, "_tx_empty"}, bus16.tx_empty, m_empty);
        chk({tag, "_rx_ready"}, bus16.rx_ready, m_rdy);
        chk({tag, "_overrun"},  bus16.overrun,  m_over);
        chk({tag, "_underrun"}, bus16.underrun, m_under);
        chk({tag, "_rx"},       bus16.rx,       m_rx);
    endtask

    task automatic cpu_write(input logic [15:0] d);
        bus16.we = 1'b1; bus16.tx = d;
        @(negedge clk);
        bus16.we = 1'b0;
        m_write(d);
    endtask

    task automatic cpu_read();
        bus16.rd = 1'b1;
        @(negedge clk);
        bus16.rd = 1'b0;
        m_rdy = 1'b0;
    endtask

    task automatic cpu_clr();
        bus16.clr_err = 1'b1;
        @(negedge clk);
        bus16.clr_err = 1'b0;
        m_clr();
    endtask

    task automatic select();
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
        chk("active", act16, 1'b1);
        chk("miso_oe", oe16, 1'b1);
    endtask

    task automatic deselect();
        cs_n = 1'b1;
        repeat (H) @(negedge clk);
        chk("inactive", act16, 1'b0);
    endtask

    // One mode-3 word (or its first nbits). coll: 1 rd at completion,
    // 2 we at word start with cdat, 3 clr_err at word start.
    task automatic spi_word(input logic [15:0] d, input int nbits, input int coll,
                            input logic [15:0] cdat, output logic [7:0] got8);
        logic [15:0] exp_tx, got16;
        logic        last;
        exp_tx = '0; got16 = '0; got8 = '0;
        for (int i = 0; i < nbits; i++) begin
            sck  = 1'b0;
            mosi = d[15-i];
            if (i == 0) begin
                if (coll == 3) m_clr();
                exp_tx = m_start();
                if (coll == 2) m_write(cdat);
            end
            repeat (2) @(negedge clk);
            if (i == 0 && coll == 2) begin bus16.we = 1'b1; bus16.tx = cdat; end
            if (i == 0 && coll == 3) bus16.clr_err = 1'b1;
            @(negedge clk);
            bus16.we = 1'b0; bus16.clr_err = 1'b0;
            repeat (H - 3) @(negedge clk);
            got16 = {got16[14:0], miso16};
            got8  = {got8[6:0], miso8};
            sck   = 1'b1;
            last  = (i == nbits - 1) && (nbits == 16);
            if (last) m_complete(d, coll == 1);
            repeat (2) @(negedge clk);
            if (last && coll == 1) bus16.rd = 1'b1;
            @(negedge clk);
            bus16.rd = 1'b0;
            repeat (H - 3) @(negedge clk);
        end
        if (nbits == 16) chk("miso_word", got16, exp_tx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  g8;
        logic [15:0] d;
        int          op, nw, nb, cl;
        bus16.we = 1'b0; bus16.tx = '0; bus16.rd = 1'b0; bus16.clr_err = 1'b0;
        bus8.we  = 1'b0; bus8.tx  = '0; bus8.rd  = 1'b0; bus8.clr_err  = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_miso", miso16, 1'b0);
        chk("rst_oe", oe16, 1'b0);
        chk("rst_active", act16, 1'b0);
        check_flags("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single word
        cpu_write(16'hA55A);
        select();
        spi_word(16'h1234, 16, 0, '0, g8);
        deselect();
        check_flags("single");

        // Back-to-back with one holding load and no read between
        cpu_read();
        cpu_write(16'hC3C3);
        select();
        spi_word(16'h0001, 16, 0, '0, g8);
        spi_word(16'hFFFF, 16, 0, '0, g8);
        deselect();
        check_flags("b2b");

        // Abort after 7 bits, then a full word from bit 0
        cpu_clr();
        select();
        spi_word(16'h5555, 7, 0, '0, g8);
        deselect();
        check_flags("abort");
        cpu_read();
        select();
        spi_word(16'h8001, 16, 0, '0, g8);
        deselect();
        check_flags("after_abort");

        // Collisions
        cpu_clr();
        cpu_write(16'h1111);
        select();
        spi_word(16'h2222, 16, 1, '0, g8);
        deselect();
        check_flags("coll_rd");
        cpu_write(16'h3333);
        select();
        spi_word(16'h4444, 16, 2, 16'h5555, g8);
        check_flags("coll_we");
        spi_word(16'h6666, 16, 0, '0, g8);
        spi_word(16'h7777, 16, 3, '0, g8);
        deselect();
        check_flags("coll_clr");

        // Reset in the middle of a word
        cpu_write(16'hABCD);
        select();
        spi_word(16'h1357, 9, 0, '0, g8);
        reset = 1'b1;
        @(negedge clk);
        m_reset();
        chk("mid_rst_miso", miso16, 1'b0);
        chk("mid_rst_oe", oe16, 1'b0);
        chk("mid_rst_active", act16, 1'b0);
        chk("mid_rst_rdy8", bus8.rx_ready, 1'b0);
        check_flags("mid_rst");
        reset = 1'b0;
        deselect();
        select();
        spi_word(16'h5AA5, 16, 0, '0, g8);
        deselect();
        check_flags("post_rst");

        // 8-bit instance
        bus8.rd = 1'b1; bus8.we = 1'b1; bus8.tx = 8'hE7;
        @(negedge clk);
        bus8.rd = 1'b0; bus8.we = 1'b0;
        chk("w8_rdy_before", bus8.rx_ready, 1'b0);
        select();
        spi_word({8'h3C, 8'h00}, 8, 0, '0, g8);
        chk("w8_rdy", bus8.rx_ready, 1'b1);
        chk("w8_rx", bus8.rx, 8'h3C);
        chk("w8_miso", g8, 8'hE7);
        deselect();
        check_flags("w8_side");

        // Randomised traffic
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: cpu_write(16'($urandom()));
                1: cpu_read();
                2: cpu_clr();
                default: begin
                    nw = $urandom_range(1, 3);
                    select();
                    for (int w = 0; w < nw; w++) begin
                        d  = 16'($urandom());
                        cl = $urandom_range(0, 3);
                        nb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : 16;
                        if (m_rdy && d == m_rx) d = d ^ 16'h0001;
                        spi_word(d, nb, cl, 16'($urandom()), g8);
                        if (nb != 16) break;
                    end
                    deselect();
                end
            endcase
            check_flags("rand");
        end

        repeat (5) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI peripheral (responder) for the j1a I/O space: the far end of the SPI link driven by our spimaster.
- Lets the FPGA act as an SPI slave to an external controller.
- Oversamples external CS_N/SCK/MOSI on clk and shifts MSB-first words of WIDTH bits.
- Presents a transmit holding register and a receive register with ready/overrun/underrun flags to the CPU bus.

Parameters:
- WIDTH, 16, bits per word (8 or 16 supported).
- TX_IDLE, 0, word shifted out when the transmit holding register is empty at word start.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cs_n  in  1  external chip select, active low, asynchronous to clk
- sck  in  1  external SPI clock, idles high (mode 3), asynchronous
- mosi  in  1  external serial data in
- miso  out  1  serial data out
- miso_oe  out  1  tristate enable for miso; 1 while selected
- we  in  1  write strobe: load tx into transmit holding register
- tx  in  WIDTH  transmit data
- tx_empty  out  1  holding register free
- rd  in  1  read strobe: acknowledge rx, clears rx_ready
- rx  out  WIDTH  last completed received word
- rx_ready  out  1  unread word in rx
- clr_err  in  1  clears overrun and underrun
- overrun  out  1  sticky: word completed while rx_ready was set
- underrun  out  1  sticky: word started with empty holding register
- active  out  1  synchronised chip select asserted

Behaviour:
- Reset values:
  - miso=0, miso_oe=0, tx_empty=1, rx=0, rx_ready=0, overrun=0, underrun=0, active=0.
  - Internal: shift registers 0, bit counter 0, synchronised sck=1, synchronised cs_n=1.
- Synchronisation:
  - cs_n, sck and mosi each pass through 2 flops.
  - Edge detect compares the 2nd flop with a 3rd flop.
  - Edges act 3 clk after the pin changes.
- External timing requirement: SCK high and low times >= 4 clk periods; CS_N setup/hold to SCK >= 4 clk.
  - Note: spimaster toggles SCL every clk, so spimaster cannot drive this block directly at full rate.
- active = NOT synchronised cs_n. miso_oe = active.
- Deselected (active=0):
  - Bit counter held at 0.
  - Partial receive data discarded.
  - miso holds its last value.
- Falling sck edge while active:
  - If bit counter == 0 (word start): transmit shift register <= holding register if tx_empty=0, then tx_empty <= 1. Otherwise shift register <= TX_IDLE and underrun <= 1.
  - Otherwise: transmit shift register shifts left by one.
  - miso = shift register MSB, registered.
- Rising sck edge while active:
  - Receive shift register <= {rs[WIDTH-2:0], synchronised mosi}.
  - Bit counter increments.
  - When the counter reaches WIDTH it wraps to 0 (word complete) in the same cycle, and:
    - rx <= the completed word (including the bit just sampled).
    - rx_ready <= 1.
    - If rx_ready was already 1 and rd is not asserted that cycle, overrun <= 1.
    - rx is overwritten regardless.
- Continuous transfers: while cs_n stays low, the next word starts on the next falling edge; no gap required.
- Chip select deasserted mid-word:
  - Counter resets to 0; no rx update.
  - A holding word consumed at that word's start stays consumed.
- CPU side:
  - we: holding <= tx, tx_empty <= 0. A write while tx_empty=0 overwrites silently.
  - we in the same cycle as a word-start consumption: the consumed word is the old holding value; the new write lands, tx_empty=0.
  - rd: rx_ready <= 0, unless a word completes in the same cycle, in which case rx_ready stays 1 with the new word and no overrun.
  - clr_err: overrun <= 0 and underrun <= 0. A set event in the same cycle wins (flag stays 1).
- reset mid-transfer returns every register to reset values on the next clk edge. The current external transfer is lost; the block resynchronises on the next cs_n falling edge.

Test Plan:
- Single word:
  - Stimulus: we with tx=16'hA55A; controller asserts cs_n, sends 16'h1234 in mode 3 with 5-clk half periods, deasserts.
  - Required: miso shows A55A MSB-first; rx=16'h1234; rx_ready=1; tx_empty=1; no error flags.
- Back-to-back:
  - Stimulus: two words, 16'h0001 then 16'hFFFF, without lifting cs_n; no rd between them; holding loaded only once (16'hC3C3).
  - Required: second word transmitted as TX_IDLE=0; underrun=1; overrun=1; rx=16'hFFFF.
- Abort:
  - Stimulus: cs_n raised after 7 bits.
  - Required: rx and rx_ready unchanged. Next full word 16'h8001 received correctly from bit 0.
- Collisions:
  - Stimulus: rd coincident with word completion; we coincident with word-start consumption; clr_err coincident with underrun set.
  - Required: rx_ready=1 and overrun=0; tx_empty=0 holding the new value; underrun=1.
- Reset mid-word:
  - Stimulus: reset pulsed at bit 9.
  - Required: all outputs at reset values the next cycle; a following full transfer of 16'h5AA5 received correctly.
- WIDTH=8 instance:
  - Stimulus: 8'h3C in, 8'hE7 out.
  - Required: rx_ready after 8 rising edges; rx=8'h3C.
